// File: rtl/shift_unit.sv
// Multi-bit shift/rotate unit: one start request runs load, shift or rotate by a
// programmable amount, one bit position per clock, with a busy/done handshake.
module shift_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] in_value,
    output logic [WIDTH-1:0] value,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_SLL  = 3'd1,
        OP_SRL  = 3'd2,
        OP_SRA  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_t;

    state_t           state;
    op_t              op_q;
    logic [AMT_W-1:0] count;
    logic [WIDTH-1:0] data;
    logic             out_bit;
    logic [WIDTH:0]   stepped;   // {bit moved out, next register value}

    always_comb begin
        stepped = {1'b0, data};
        case (op_q)
            OP_SLL:  stepped = {data[WIDTH-1], data[WIDTH-2:0], 1'b0};
            OP_SRL:  stepped = {data[0], 1'b0, data[WIDTH-1:1]};
            OP_SRA:  stepped = {data[0], data[WIDTH-1], data[WIDTH-1:1]};
            OP_ROL:  stepped = {data[WIDTH-1], data[WIDTH-2:0], data[WIDTH-1]};
            OP_ROR:  stepped = {data[0], data[0], data[WIDTH-1:1]};
            default: stepped = {1'b0, data};
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= OP_LOAD;
            count   <= '0;
            data    <= '0;
            out_bit <= 1'b0;
            value   <= '0;
            carry   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= op_t'(op);
                        count   <= amount;
                        out_bit <= 1'b0;
                        if (op_t'(op) == OP_LOAD) begin
                            data  <= in_value;
                            state <= FINISH;
                        end else if (amount == '0 || op[2:1] == 2'b11) begin
                            state <= FINISH;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data    <= stepped[WIDTH-1:0];
                    out_bit <= stepped[WIDTH];
                    count   <= count - AMT_W'(1);
                    if (count == AMT_W'(1)) state <= FINISH;
                end
                FINISH: begin
                    value <= data;
                    carry <= out_bit;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/shift_unit.md
Name: shift_unit

Overview:
Parametrised multi-bit shift/rotate unit. It is the successor to the single-bit load/shift register in the ATM datapath, used for digit/PIN packing and amount scaling. It holds an internal WIDTH-bit register and accepts one operation per start pulse: load, logical or arithmetic shift, or rotate, by a programmable amount. Each operation executes one bit position per cycle under a busy/done handshake. The result and carry-out are published only when the operation completes.

Parameters:
WIDTH, 8, data width of the register and the in/out values (>= 2)
AMT_W, 3, width of the shift-amount port (max amount 2^AMT_W - 1)

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  3  000 LOAD, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR, 110/111 reserved
amount  input  AMT_W  number of single-bit steps for shift/rotate ops
in_value  input  WIDTH  data for LOAD
value  output  WIDTH  registered result, updated only on completion
carry  output  1  last bit shifted or rotated out, updated with value
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse, high in the cycle value/carry first show the new result

Behaviour:
- Reset: clk is the single clock. rst is synchronous and active-high. On reset: state=IDLE, internal reg=0, count=0, value=0, carry=0, busy=0, done=0.
- Reset mid-operation: aborts the operation; no done pulse; all outputs return to their reset values.
- busy = (state != IDLE). done is a registered pulse.
- States and transitions:
  - IDLE: start=1 at edge E0 latches op and amount, and sets count=amount.
    - LOAD: internal <= in_value at E0; go to FINISH.
    - amount=0 or reserved op: go to FINISH; internal unchanged.
    - Otherwise: go to SHIFT.
  - SHIFT: at each edge, perform one single-bit step on internal, track the bit moved out, and decrement count. The step that brings count to 0 transitions to FINISH.
  - FINISH: at the next edge, value <= internal, carry <= tracked bit, done <= 1, state <= IDLE.
- Latency:
  - LOAD / amount 0 / reserved: done is high in the cycle after edge E0+1.
  - Shift by N: done is high after edge E0+N+1.
  - busy is high N+1 cycles; done and busy are never high together.
- start while busy (SHIFT or FINISH) is ignored and not queued. A new start is accepted in the done cycle. done never asserts twice for one request.
- Single-bit step definitions:
  - SLL: {r[W-2:0],0}, out=r[W-1]
  - SRL: {0,r[W-1:1]}, out=r[0]
  - SRA: {r[W-1],r[W-1:1]}, out=r[0]
  - ROL: {r[W-2:0],r[W-1]}, out=r[W-1]
  - ROR: {r[0],r[W-1:1]}, out=r[0]
- carry=0 for LOAD, amount 0, and reserved ops.
- amount >= WIDTH (only possible when AMT_W is widened): still one step per cycle.
  - SLL/SRL yield 0.
  - SRA yields all sign bits.
  - Rotates wrap modulo WIDTH.
  - carry follows the step definitions.
- The internal reg persists between operations, so successive shift ops chain on the previous result. in_value is read only on LOAD at E0.
- value is stable except at the FINISH edge. Intermediate shift states are never visible on value.

Test Plan:
1. Reset, then LOAD in_value=8'hA5 → done one cycle, 2 edges after start; value=8'hA5, carry=0, busy high for 1 cycle.
2. After (1), SLL amount=3 → busy high 4 cycles, then done with value=8'h28, carry=1. value holds 8'hA5 throughout busy.
3. Reload 8'hA5, then SRA amount=2 → value=8'hE9, carry=0. Reload 8'hA5, then SRL amount=2 → value=8'h29, carry=0.
4. LOAD 8'h81, then ROR amount=7 → value=8'h03, carry=0. Then ROL amount=1 → value=8'h06, carry=0.
5. SLL amount=0 → done after 2 edges, value unchanged, carry=0. start pulsed during a busy shift → ignored: exactly one done, result unaffected. Back-to-back start in the done cycle → accepted.
6. Start SRL amount=7 on 8'hFF and assert rst at the 3rd busy cycle → next cycle value=0, carry=0, busy=0. No done pulse ever appears for that op.
